face_box_overlay: RTL and testbench
===================================

Name: face_box_overlay

Overview:
- Downstream of the face bounding-box locator; consumes its x_min/x_max/y_min/y_max outputs.
- Once per frame, latches the box, validates it, optionally smooths it and applies a miss-tolerance hold.
- Draws a rectangle outline of configurable thickness and colour over the RGB565 display stream heading to the LCD.
- Latency is one clock; sync signals pass through delayed to match.

Parameters:
- H_ACT, 640, active pixels per line; a box is valid only if x_max < H_ACT.
- V_ACT, 480, active lines per frame; a box is valid only if y_max < V_ACT.
- THICK, 2, border thickness in pixels (1..8).
- BOX_COLOR, 16'hF800, RGB565 colour of the border (red).
- HOLD_FRAMES, 3, number of consecutive invalid frames before the box is dropped (1..15).
- SMOOTH_EN, 1, 1 = average each new box with the displayed box; 0 = replace it.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- box_x_min  in  12  left edge from the locator
- box_x_max  in  12  right edge from the locator
- box_y_min  in  12  top edge from the locator
- box_y_max  in  12  bottom edge from the locator
- in_vsync  in  1  frame sync, active high
- in_href  in  1  line valid
- in_de  in  1  pixel valid (clken)
- in_data  in  16  RGB565 pixel
- lcd_x  in  12  column of in_data, same cycle
- lcd_y  in  12  row of in_data, same cycle
- out_vsync  out  1  in_vsync delayed 1 clk
- out_href  out  1  in_href delayed 1 clk
- out_de  out  1  in_de delayed 1 clk
- out_data  out  16  pixel with overlay, 1 clk latency
- box_valid  out  1  a box is currently being drawn

Behaviour:
- Reset (async, active-low): all outputs 0; displayed box registers 0; miss counter 0; state NO_BOX; vsync history 0.
- Frame boundary: the rising edge of in_vsync, detected against a registered copy of in_vsync. The box is sampled and the state machine steps only on this 1-cycle pulse.
- Sampled box is valid iff x_min <= x_max, y_min <= y_max, x_max < H_ACT and y_max < V_ACT.
  - The locator's empty-frame output (x_min=640, x_max=0) is therefore invalid.
- NO_BOX state:
  - valid sample -> load box directly (no averaging), miss counter 0, go to TRACK.
  - invalid sample -> stay in NO_BOX.
- TRACK state:
  - valid sample -> update box, miss counter 0, stay in TRACK.
  - invalid sample -> miss counter = 1; go to COAST if HOLD_FRAMES > 1, otherwise go to NO_BOX.
- COAST state:
  - valid sample -> update box, miss counter 0, go to TRACK.
  - invalid sample -> miss counter +1; go to NO_BOX when the counter reaches HOLD_FRAMES; the box is kept unchanged while coasting.
- Box update:
  - SMOOTH_EN=1: each coordinate = (displayed + sampled) >> 1, computed 13 bits wide and truncated toward zero.
  - SMOOTH_EN=0: each coordinate = sampled value.
- box_valid = 1 in TRACK or COAST; it changes only on the boundary pulse.
- Displayed box registers change only on the boundary pulse, so there is no tearing. Changes to box_* mid-frame have no effect.
- Border hit: box_valid, x_min <= lcd_x <= x_max, y_min <= lcd_y <= y_max, and at least one of the following, each computed as an unsigned 12-bit difference:
  - (lcd_x - x_min) < THICK
  - (x_max - lcd_x) < THICK
  - (lcd_y - y_min) < THICK
  - (y_max - lcd_y) < THICK
- A box narrower than 2*THICK is drawn fully filled.
- Output stage (one register stage):
  - out_data = BOX_COLOR when in_de and border hit; in_data when in_de and no hit; 16'h0000 when in_de = 0.
  - out_vsync, out_href and out_de are the corresponding inputs registered once.
- Simultaneous events: the boundary pulse uses the box_* values present in the pulse cycle. Pixels in that same cycle are drawn with the old box.
- Reset mid-frame: immediate return to NO_BOX with outputs cleared. The first boundary after release samples normally.

Test Plan:
- Reset then a 640x480 frame with box inputs at the empty values (640/0/480/0) -> box_valid=0; out_data equals in_data delayed 1 clk for every pixel; out_data=0 when de=0.
- Box 100..199 x 50..149, one boundary pulse, THICK=2 -> next frame:
  - (100,50)=F800, (101,100)=F800, (199,149)=F800.
  - (102,100) = input pixel; (150,100) = input pixel; (99,50) = input pixel.
- SMOOTH_EN=1: displayed box 100..199/50..149, then sampled box 201..300/51..150 -> displayed box becomes 150..249/50..149.
- HOLD_FRAMES=3: track a valid box, then 3 invalid frames -> box_valid stays 1 and the box is unchanged after boundaries 1 and 2; box_valid=0 after boundary 3 with no border drawn. A valid frame inside the hold returns to TRACK with the miss counter cleared.
- Change box_* mid-frame (at line 200) -> the rest of the frame is drawn with the old box; the new box appears only after the next in_vsync rise.
- Assert rst_n low mid-line while in TRACK -> out_* = 0 asynchronously and box_valid=0; after release the stream passes through unmodified until a valid boundary sample.

Source files
------------

// File: rtl/face_box_overlay.sv
// face_box_overlay: per-frame face box latch with validation, smoothing and miss hold,
// drawn as a coloured outline over an RGB565 stream with one clock of latency.
module face_box_overlay #(
    parameter int          H_ACT       = 640,
    parameter int          V_ACT       = 480,
    parameter int          THICK       = 2,
    parameter logic [15:0] BOX_COLOR   = 16'hF800,
    parameter int          HOLD_FRAMES = 3,
    parameter int          SMOOTH_EN   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] box_x_min,
    input  logic [11:0] box_x_max,
    input  logic [11:0] box_y_min,
    input  logic [11:0] box_y_max,
    input  logic        in_vsync,
    input  logic        in_href,
    input  logic        in_de,
    input  logic [15:0] in_data,
    input  logic [11:0] lcd_x,
    input  logic [11:0] lcd_y,
    output logic        out_vsync,
    output logic        out_href,
    output logic        out_de,
    output logic [15:0] out_data,
    output logic        box_valid
);
    localparam logic [1:0] NO_BOX = 2'd0;
    localparam logic [1:0] TRACK  = 2'd1;
    localparam logic [1:0] COAST  = 2'd2;
    localparam logic [11:0] TH = 12'(THICK);

    logic [1:0]  state;
    logic [3:0]  miss;
    logic [11:0] bx0, bx1, by0, by1;
    logic        vs_d, frame, s_ok, hit;
    logic [11:0] dx0, dx1, dy0, dy1;

    function automatic logic [11:0] upd(input logic [11:0] old, input logic [11:0] s);
        logic [12:0] sum;
        sum = {1'b0, old} + {1'b0, s};
        return (SMOOTH_EN != 0) ? sum[12:1] : s;
    endfunction

    assign frame     = in_vsync & ~vs_d;
    assign s_ok      = (box_x_min <= box_x_max) && (box_y_min <= box_y_max) &&
                       (box_x_max < 12'(H_ACT)) && (box_y_max < 12'(V_ACT));
    assign box_valid = state != NO_BOX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NO_BOX;
            miss  <= '0;
            vs_d  <= 1'b0;
            bx0   <= '0;
            bx1   <= '0;
            by0   <= '0;
            by1   <= '0;
        end else begin
            vs_d <= in_vsync;
            if (frame) begin
                if (s_ok) begin
                    // first acquisition loads raw; averaging only refines an existing box
                    bx0   <= (state == NO_BOX) ? box_x_min : upd(bx0, box_x_min);
                    bx1   <= (state == NO_BOX) ? box_x_max : upd(bx1, box_x_max);
                    by0   <= (state == NO_BOX) ? box_y_min : upd(by0, box_y_min);
                    by1   <= (state == NO_BOX) ? box_y_max : upd(by1, box_y_max);
                    miss  <= '0;
                    state <= TRACK;
                end else if (state == TRACK) begin
                    miss  <= 4'd1;
                    state <= (HOLD_FRAMES > 1) ? COAST : NO_BOX;
                end else if (state == COAST) begin
                    miss  <= miss + 4'd1;
                    state <= (miss + 4'd1 >= 4'(HOLD_FRAMES)) ? NO_BOX : COAST;
                end
            end
        end
    end

    always_comb begin
        dx0 = lcd_x - bx0;
        dx1 = bx1 - lcd_x;
        dy0 = lcd_y - by0;
        dy1 = by1 - lcd_y;
        hit = box_valid && lcd_x >= bx0 && lcd_x <= bx1 && lcd_y >= by0 && lcd_y <= by1 &&
              (dx0 < TH || dx1 < TH || dy0 < TH || dy1 < TH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vsync <= 1'b0;
            out_href  <= 1'b0;
            out_de    <= 1'b0;
            out_data  <= '0;
        end else begin
            out_vsync <= in_vsync;
            out_href  <= in_href;
            out_de    <= in_de;
            out_data  <= !in_de ? 16'h0000 : hit ? BOX_COLOR : in_data;
        end
    end
endmodule

// File: tb/tb_face_box_overlay.sv
// tb_face_box_overlay: directed and randomized checks of face_box_overlay against
// a frame-level reference model of box tracking and border drawing.
module tb_face_box_overlay;
    localparam int T = 2, HOLD = 3;

    logic        clk = 0, rst_n = 0;
    logic [11:0] box_x_min = 0, box_x_max = 0, box_y_min = 0, box_y_max = 0;
    logic        in_vsync = 0, in_href = 0, in_de = 0;
    logic [15:0] in_data = 0;
    logic [11:0] lcd_x = 0, lcd_y = 0;
    logic        out_vsync, out_href, out_de, box_valid;
    logic [15:0] out_data;

    int tests = 0, fails = 0;
    bit m_valid = 0;
    int m_miss = 0, mx0 = 0, mx1 = 0, my0 = 0, my1 = 0;

    face_box_overlay dut (
        .clk(clk), .rst_n(rst_n),
        .box_x_min(box_x_min), .box_x_max(box_x_max), .box_y_min(box_y_min), .box_y_max(box_y_max),
        .in_vsync(in_vsync), .in_href(in_href), .in_de(in_de), .in_data(in_data),
        .lcd_x(lcd_x), .lcd_y(lcd_y),
        .out_vsync(out_vsync), .out_href(out_href), .out_de(out_de), .out_data(out_data),
        .box_valid(box_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit hit_m(input int x, input int y);
        if (!m_valid || x < mx0 || x > mx1 || y < my0 || y > my1) return 0;
        return (x - mx0 < T) || (mx1 - x < T) || (y - my0 < T) || (my1 - y < T);
    endfunction

    function automatic logic [15:0] exp_px(input int x, input int y, input bit de, input logic [15:0] d);
        return !de ? 16'h0000 : hit_m(x, y) ? 16'hF800 : d;
    endfunction

    task automatic model_frame(input int x0, input int x1, input int y0, input int y1);
        if (x0 <= x1 && y0 <= y1 && x1 < 640 && y1 < 480) begin
            if (m_valid) begin
                mx0 = (mx0 + x0) / 2; mx1 = (mx1 + x1) / 2;
                my0 = (my0 + y0) / 2; my1 = (my1 + y1) / 2;
            end else begin
                mx0 = x0; mx1 = x1; my0 = y0; my1 = y1;
            end
            m_valid = 1;
            m_miss = 0;
        end else if (m_valid) begin
            m_miss++;
            if (m_miss >= HOLD) m_valid = 0;
        end
    endtask

    task automatic pix(input int x, input int y, input bit de, input logic [15:0] d);
        logic [15:0] e;
        @(negedge clk);
        in_vsync = 0; in_href = 1; in_de = de; in_data = d;
        lcd_x = 12'(x); lcd_y = 12'(y);
        e = exp_px(x, y, de, d);
        @(posedge clk); #1;
        chk("pix_data", {16'h0, out_data}, {16'h0, e});
        chk("pix_de", {31'h0, out_de}, {31'h0, de});
    endtask

    task automatic pixk(input int x, input int y, input logic [15:0] d, input logic [15:0] e);
        @(negedge clk);
        in_vsync = 0; in_href = 1; in_de = 1; in_data = d;
        lcd_x = 12'(x); lcd_y = 12'(y);
        @(posedge clk); #1;
        chk($sformatf("pixel_%0d_%0d", x, y), {16'h0, out_data}, {16'h0, e});
    endtask

    // boundary cycle also carries a pixel, which must still use the old box
    task automatic frame(input int x0, input int x1, input int y0, input int y1);
        logic [15:0] d, e;
        @(negedge clk);
        d = 16'($urandom);
        box_x_min = 12'(x0); box_x_max = 12'(x1); box_y_min = 12'(y0); box_y_max = 12'(y1);
        in_vsync = 1; in_href = 0; in_de = 1; in_data = d;
        lcd_x = 12'(mx0); lcd_y = 12'(my0);
        e = exp_px(mx0, my0, 1, d);
        @(posedge clk); #1;
        chk("bnd_data", {16'h0, out_data}, {16'h0, e});
        chk("bnd_vsync", {31'h0, out_vsync}, 32'd1);
        model_frame(x0, x1, y0, y1);
        chk("box_valid", {31'h0, box_valid}, {31'h0, m_valid});
        @(negedge clk);
        in_vsync = 0; in_de = 0;
    endtask

    function automatic int near(input int a, input int b);
        int v;
        v = (($urandom % 2) ? a : b) + int'($urandom_range(0, 6)) - 3;
        return v < 0 ? 0 : v;
    endfunction

    task automatic rand_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom % 4 == 0) pix($urandom_range(0, 639), $urandom_range(0, 479), $urandom % 5 != 0, 16'($urandom));
            else pix(near(mx0, mx1), near(my0, my1), $urandom % 5 != 0, 16'($urandom));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", {16'h0, out_data}, 32'h0);
        chk("rst_de", {31'h0, out_de}, 32'h0);
        chk("rst_vsync", {31'h0, out_vsync}, 32'h0);
        chk("rst_href", {31'h0, out_href}, 32'h0);
        chk("rst_valid", {31'h0, box_valid}, 32'h0);
        @(negedge clk) rst_n = 1;

        frame(640, 0, 480, 0);
        pix(0, 0, 0, 16'h1234);
        rand_pixels(40);

        frame(100, 199, 50, 149);
        pixk(100, 50, 16'h1111, 16'hF800);
        pixk(101, 100, 16'h2222, 16'hF800);
        pixk(199, 149, 16'h3333, 16'hF800);
        pixk(102, 100, 16'h4444, 16'h4444);
        pixk(150, 100, 16'h5555, 16'h5555);
        pixk(99, 50, 16'h6666, 16'h6666);
        rand_pixels(60);

        frame(201, 300, 51, 150);
        pixk(150, 100, 16'h0101, 16'hF800);
        pixk(151, 100, 16'h0202, 16'hF800);
        pixk(152, 100, 16'h0303, 16'h0303);
        pixk(249, 149, 16'h0404, 16'hF800);
        pixk(250, 100, 16'h0505, 16'h0505);
        pixk(149, 100, 16'h0606, 16'h0606);

        for (int k = 1; k <= 3; k++) begin
            frame(640, 0, 480, 0);
            chk($sformatf("hold_valid_%0d", k), {31'h0, box_valid}, {31'h0, k < 3});
            pixk(150, 50, 16'h0A0A, k < 3 ? 16'hF800 : 16'h0A0A);
        end
        frame(100, 199, 50, 149);
        frame(640, 0, 480, 0);
        frame(640, 0, 480, 0);
        frame(100, 199, 50, 149);
        frame(640, 0, 480, 0);
        frame(640, 0, 480, 0);
        chk("hold_cleared", {31'h0, box_valid}, 32'd1);
        frame(640, 0, 480, 0);
        chk("hold_drop", {31'h0, box_valid}, 32'd0);

        frame(100, 199, 50, 149);
        pixk(100, 100, 16'h7777, 16'hF800);
        @(negedge clk);
        box_x_min = 300; box_x_max = 399; box_y_min = 250; box_y_max = 349;
        pixk(100, 200, 16'h7878, 16'h7878);
        pixk(300, 300, 16'h7979, 16'h7979);
        pixk(199, 149, 16'h7A7A, 16'hF800);
        frame(300, 399, 250, 349);
        pixk(200, 200, 16'h7B7B, 16'hF800);
        pixk(100, 100, 16'h7C7C, 16'h7C7C);
        rand_pixels(30);

        for (int f = 0; f < 20; f++) begin
            int x0, x1, y0, y1;
            x0 = $urandom_range(0, 600); x1 = x0 + $urandom_range(0, 60);
            y0 = $urandom_range(0, 450); y1 = y0 + $urandom_range(0, 40);
            if ($urandom % 5 == 0) begin x0 = x1 + 1; end
            frame(x0, x1, y0, y1);
            rand_pixels(30);
        end

        frame(100, 199, 50, 149);
        if (!m_valid) frame(100, 199, 50, 149);
        pix(mx0, my0, 1, 16'h9999);
        @(negedge clk);
        in_de = 1; in_href = 1; lcd_x = 12'(mx0); lcd_y = 12'(my0); in_data = 16'h9A9A;
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        chk("arst_data", {16'h0, out_data}, 32'h0);
        chk("arst_de", {31'h0, out_de}, 32'h0);
        chk("arst_href", {31'h0, out_href}, 32'h0);
        chk("arst_valid", {31'h0, box_valid}, 32'h0);
        m_valid = 0; m_miss = 0; mx0 = 0; mx1 = 0; my0 = 0; my1 = 0;
        @(posedge clk); #1;
        chk("arst_hold", {16'h0, out_data}, 32'h0);
        @(negedge clk) rst_n = 1;
        pixk(100, 50, 16'h5A5A, 16'h5A5A);
        pixk(199, 149, 16'h5B5B, 16'h5B5B);
        frame(100, 199, 50, 149);
        pixk(100, 50, 16'h5C5C, 16'hF800);
        rand_pixels(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
